// File: rtl/fifo_sched_pkg.sv
// rtl/fifo_sched_pkg.sv - shared types and helpers for the round-robin FIFO drain scheduler
//
// Purpose: source-index type, one-hot decode and rotating-priority scan.
// The helpers work on fixed maximum-width vectors so that any instance with
// NSRC <= MAX_NSRC can use them. Callers zero-extend their inputs and slice
// the results back down.
// Ports: none (package).
package fifo_sched_pkg;

  localparam int MAX_NSRC  = 16;
  localparam int MAX_SRC_W = 4;

  typedef logic [MAX_SRC_W-1:0] src_idx_t;

  // One-hot decode of idx. Bits at positions n and above always read 0.
  function automatic logic [MAX_NSRC-1:0] onehot(input src_idx_t idx, input int n);
    logic [MAX_NSRC-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_NSRC; i++) begin
      if (i < n && src_idx_t'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Scans mask starting at start and moving upwards, wrapping modulo n.
  // Returns {found, idx}, where idx is the first set position that the scan visits.
  function automatic logic [MAX_SRC_W:0] rr_scan(input logic [MAX_NSRC-1:0] mask,
                                                 input src_idx_t            start,
                                                 input int                  n);
    logic     found;
    src_idx_t idx;
    int       k;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < MAX_NSRC; i++) begin
      if (i < n) begin
        k = int'(start) + i;
        if (k >= n) k = k - n;
        if (!found && mask[k]) begin
          found = 1'b1;
          idx   = src_idx_t'(k);
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority encoder
//
// Purpose: returns the first set bit of i_mask, scanning upwards from i_start
// and wrapping. The scheduler passes i_start = cur+1, so cur is visited last.
// Ports:
//   i_mask   in  NSRC   candidate mask
//   i_start  in  SRC_W  first index scanned
//   o_found  out 1      any bit of i_mask set
//   o_idx    out SRC_W  winning index (0 when !o_found)
module rr_pick
  import fifo_sched_pkg::*;
#(
  parameter int NSRC  = 4,
  parameter int SRC_W = $clog2(NSRC)
) (
  input  logic [NSRC-1:0]  i_mask,
  input  logic [SRC_W-1:0] i_start,
  output logic             o_found,
  output logic [SRC_W-1:0] o_idx
);

  logic [MAX_SRC_W:0] w_res;

  always_comb begin
    w_res = rr_scan(MAX_NSRC'(i_mask), src_idx_t'(i_start), NSRC);
  end

  assign o_found = w_res[MAX_SRC_W];
  assign o_idx   = SRC_W'(w_res[MAX_SRC_W-1:0]);

endmodule

// File: rtl/fifo_rr_drain_sched.sv
// rtl/fifo_rr_drain_sched.sv - round-robin burst-limited drain of NSRC FIFOs into one stream
//
// Purpose: pops at most one FIFO per clock. The beat is captured in a 1-entry
// registered output stage. A source keeps the grant for up to BURST
// consecutive pops, and then the grant rotates to the next non-empty source.
// Ports:
//   clk       in  1            clock
//   rstn      in  1            synchronous reset, active-low
//   i_en      in  1            scheduler enable (low: no new pops, output still drains)
//   i_empty   in  NSRC         per-FIFO empty flags
//   i_rddata  in  NSRC*DATA_W  per-FIFO read data, source k at [k*DATA_W +: DATA_W]
//   o_rden    out NSRC         per-FIFO read enable, one-hot or zero
//   m_valid   out 1            output beat valid
//   m_data    out DATA_W       output beat data
//   m_src     out SRC_W        source index of the output beat
//   m_ready   in  1            downstream accept
//   o_busy    out 1            output beat pending or any FIFO non-empty
module fifo_rr_drain_sched
  import fifo_sched_pkg::*;
#(
  parameter int NSRC   = 4,
  parameter int DATA_W = 8,
  parameter int BURST  = 2,
  parameter int SRC_W  = $clog2(NSRC)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_en,
  input  logic [NSRC-1:0]        i_empty,
  input  logic [NSRC*DATA_W-1:0] i_rddata,
  output logic [NSRC-1:0]        o_rden,
  output logic                   m_valid,
  output logic [DATA_W-1:0]      m_data,
  output logic [SRC_W-1:0]       m_src,
  input  logic                   m_ready,
  output logic                   o_busy
);

  localparam int               CNT_W   = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  logic [SRC_W-1:0]  r_cur;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [SRC_W-1:0]  r_src;

  logic              w_load;
  logic [NSRC-1:0]   w_elig;
  logic              w_keep;
  logic              w_found;
  logic [SRC_W-1:0]  w_pick;
  logic [SRC_W-1:0]  w_start;
  logic [SRC_W-1:0]  w_sel;
  logic              w_pop;
  logic [DATA_W-1:0] w_sel_data;

  assign w_load = !r_valid | m_ready;
  assign w_elig = ~i_empty & {NSRC{i_en}};

  // Stay on cur while it still has burst budget. Otherwise the scan starts at
  // cur+1 and reaches cur last, so a lone remaining source is re-granted
  // without a bubble.
  assign w_keep  = w_elig[r_cur] & (r_cnt < BURST_C);
  assign w_start = (r_cur == SRC_W'(NSRC - 1)) ? '0 : r_cur + 1'b1;

  rr_pick #(
    .NSRC  (NSRC),
    .SRC_W (SRC_W)
  ) u_rr_pick (
    .i_mask  (w_elig),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_sel      = w_keep ? r_cur : w_pick;
  // o_found is the same condition as |w_elig. Gating with rstn keeps every read
  // enable low during reset.
  assign w_pop      = rstn & w_load & w_found;
  assign w_sel_data = i_rddata[w_sel*DATA_W +: DATA_W];

  assign o_rden = w_pop ? NSRC'(onehot(src_idx_t'(w_sel), NSRC)) : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cur   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
    end else if (w_load) begin
      if (w_pop) begin
        r_valid <= 1'b1;
        r_data  <= w_sel_data;
        r_src   <= w_sel;
        if (w_keep) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cur <= w_sel;
          r_cnt <= CNT_W'(1);
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_valid = r_valid;
  assign m_data  = r_data;
  assign m_src   = r_src;
  assign o_busy  = r_valid | (|(~i_empty));

endmodule

// File: tb/tb_fifo_rr_drain_sched.sv
// tb/tb_fifo_rr_drain_sched.sv - self-checking bench for fifo_rr_drain_sched
module tb_fifo_rr_drain_sched;

  localparam int NSRC   = 4;
  localparam int DATA_W = 8;
  localparam int BURST  = 2;
  localparam int DEPTH  = 8;

  logic        clk     = 1'b0;
  logic        rstn    = 1'b0;
  logic        i_en    = 1'b1;
  logic        m_ready = 1'b1;
  logic [3:0]  i_empty;
  logic [31:0] i_rddata;
  logic [3:0]  o_rden;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [1:0]  m_src;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_rr_drain_sched #(
    .NSRC   (NSRC),
    .DATA_W (DATA_W),
    .BURST  (BURST)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_en     (i_en),
    .i_empty  (i_empty),
    .i_rddata (i_rddata),
    .o_rden   (o_rden),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_src    (m_src),
    .m_ready  (m_ready),
    .o_busy   (o_busy)
  );

  // Source FIFOs: depth 8, combinational read, reset by the same rstn
  logic [7:0] fmem [NSRC][DEPTH];
  logic [3:0] wp [NSRC];
  logic [3:0] rp [NSRC];

  for (genvar k = 0; k < NSRC; k++) begin : g_fifo
    assign i_empty[k]          = (wp[k] == rp[k]);
    assign i_rddata[k*8 +: 8]  = fmem[k][rp[k][2:0]];
  end

  always @(posedge clk) begin
    for (int k = 0; k < NSRC; k++) begin
      if (!rstn)          rp[k] <= wp[k];
      else if (o_rden[k]) rp[k] <= rp[k] + 4'd1;
    end
  end

  // Per-source expected order and the log of accepted beats
  logic [7:0] sb [NSRC][$];
  int         beat_src [$];
  logic [7:0] beat_data [$];
  int         beat_cyc [$];

  // Reference model: the granted source, its run length and the output beat
  logic       mv   = 1'b0;
  logic [7:0] md   = 8'd0;
  int         ms   = 0;
  int         mcur = 0;
  int         mcnt = 0;

  always @(negedge clk) begin : monitor
    logic [3:0] elig;
    logic [3:0] exp_rden;
    int         sel;
    bit         kept;
    elig = ~i_empty & {4{i_en}};
    sel  = -1;
    kept = 1'b0;
    if (rstn && (!mv || m_ready) && elig != 4'd0) begin
      if (elig[mcur] && mcnt < BURST) begin
        sel  = mcur;
        kept = 1'b1;
      end else begin
        for (int d = 1; d <= NSRC; d++)
          if (sel < 0 && elig[(mcur + d) % NSRC]) sel = (mcur + d) % NSRC;
      end
    end
    exp_rden = (sel >= 0) ? 4'(1 << sel) : 4'd0;

    checks++;
    if (o_rden !== exp_rden) begin
      errors++;
      $display("FAIL rden t=%0t: got %b expected %b", $time, o_rden, exp_rden);
    end
    checks++;
    if ((o_rden & i_empty) !== 4'd0) begin
      errors++;
      $display("FAIL rden_on_empty t=%0t: rden %b empty %b", $time, o_rden, i_empty);
    end
    checks++;
    if (m_valid !== mv) begin
      errors++;
      $display("FAIL m_valid t=%0t: got %b expected %b", $time, m_valid, mv);
    end
    if (mv) begin
      checks++;
      if (m_data !== md || m_src !== 2'(ms)) begin
        errors++;
        $display("FAIL beat t=%0t: got src %0d data %h expected src %0d data %h",
                 $time, m_src, m_data, ms, md);
      end
    end
    checks++;
    if (o_busy !== (mv | (|(~i_empty)))) begin
      errors++;
      $display("FAIL busy t=%0t: got %b expected %b", $time, o_busy, mv | (|(~i_empty)));
    end

    if (rstn && mv && m_ready) begin
      beat_src.push_back(int'(m_src));
      beat_data.push_back(m_data);
      beat_cyc.push_back(cyc);
      checks++;
      if (sb[ms].size() == 0) begin
        errors++;
        $display("FAIL src_order t=%0t: src %0d data %h delivered with nothing pending", $time, ms, m_data);
      end else begin
        if (sb[ms][0] !== m_data) begin
          errors++;
          $display("FAIL src_order t=%0t: src %0d got %h expected %h", $time, ms, m_data, sb[ms][0]);
        end
        void'(sb[ms].pop_front());
      end
    end

    if (!rstn) begin
      mv = 1'b0; md = 8'd0; ms = 0; mcur = 0; mcnt = 0;
      for (int k = 0; k < NSRC; k++) sb[k].delete();
    end else if (!mv || m_ready) begin
      if (sel >= 0) begin
        md = fmem[sel][rp[sel][2:0]];
        ms = sel;
        mv = 1'b1;
        if (kept) mcnt++;
        else begin
          mcur = sel;
          mcnt = 1;
        end
      end else begin
        mv = 1'b0;
      end
    end
  end

  task automatic push(input int k, input logic [7:0] d);
    if (4'(wp[k] - rp[k]) < 4'd8) begin
      fmem[k][wp[k][2:0]] = d;
      wp[k] = wp[k] + 4'd1;
      sb[k].push_back(d);
    end
  endtask

  task automatic clear_log();
    beat_src.delete();
    beat_data.delete();
    beat_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0; i_en = 1'b1; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    clear_log();
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (beat_src.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Beat i of the "four sources, four entries each" pattern
  function automatic void exp_all(input int i, output int src, output logic [7:0] data);
    int occ;
    src  = (i / 2) % 4;
    occ  = (i / 8) * 2 + (i % 2);
    data = 8'(src * 16 + occ);
  endfunction

  task automatic test_reset();
    rstn = 1'b0; i_en = 1'b1; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    checks++;
    if (o_rden !== 4'd0) begin errors++; $display("FAIL reset_rden: got %b expected 0000", o_rden); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    @(posedge clk); #1 rstn = 1'b1;
    clear_log();
  endtask

  task automatic test_single_src();
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) push(0, 8'(8'h10 + i));
    wait_beats(4, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: got %0d beats expected 4", beat_src.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (beat_src[i] !== 0 || beat_data[i] !== 8'(8'h10 + i)) begin
          errors++;
          $display("FAIL single_beat%0d: got src %0d data %h expected src 0 data %h",
                   i, beat_src[i], beat_data[i], 8'(8'h10 + i));
        end
      end
      checks++;
      if (beat_cyc[3] - beat_cyc[0] !== 3) begin
        errors++;
        $display("FAIL single_rate: got span %0d expected 3", beat_cyc[3] - beat_cyc[0]);
      end
    end
  endtask

  task automatic check_all_pattern(input string tag);
    int es;
    logic [7:0] ed;
    for (int i = 0; i < 16 && i < beat_src.size(); i++) begin
      exp_all(i, es, ed);
      checks++;
      if (beat_src[i] !== es || beat_data[i] !== ed) begin
        errors++;
        $display("FAIL %s_beat%0d: got src %0d data %h expected src %0d data %h",
                 tag, i, beat_src[i], beat_data[i], es, ed);
      end
    end
  endtask

  task automatic test_all_src();
    bit ok;
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) push(k, 8'(k * 16 + i));
    wait_beats(16, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL all_timeout: got %0d beats expected 16", beat_src.size()); end
    else begin
      check_all_pattern("all");
      checks++;
      if (beat_cyc[15] - beat_cyc[0] !== 15) begin
        errors++;
        $display("FAIL all_rate: got span %0d expected 15", beat_cyc[15] - beat_cyc[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] fd;
    logic [1:0] fs;
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) push(k, 8'(k * 16 + i));
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (beat_src.size() >= 5) break;
    end
    m_ready = 1'b0;
    @(negedge clk);
    fd = m_data;
    fs = m_src;
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", m_valid); end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== fd || m_src !== fs || o_rden !== 4'd0) begin
        errors++;
        $display("FAIL bp_freeze: got v%b d%h s%0d rden%b expected v1 d%h s%0d rden0000",
                 m_valid, m_data, m_src, o_rden, fd, fs);
      end
    end
    @(posedge clk); #1 m_ready = 1'b1;
    wait_beats(16, 60, ok);
    repeat (3) @(posedge clk);
    checks++;
    if (!ok || beat_src.size() !== 16) begin
      errors++;
      $display("FAIL bp_count: got %0d beats expected 16", beat_src.size());
    end
    check_all_pattern("bp");
  endtask

  task automatic test_empty_mid_burst();
    bit ok;
    int         es [4] = '{1, 2, 2, 2};
    logic [7:0] ed [4] = '{8'hA0, 8'hB0, 8'hB1, 8'hB2};
    do_reset();
    push(1, 8'hA0);
    for (int i = 0; i < 3; i++) push(2, 8'(8'hB0 + i));
    wait_beats(4, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_timeout: got %0d beats expected 4", beat_src.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (beat_src[i] !== es[i] || beat_data[i] !== ed[i]) begin
          errors++;
          $display("FAIL mid_beat%0d: got src %0d data %h expected src %0d data %h",
                   i, beat_src[i], beat_data[i], es[i], ed[i]);
        end
      end
      checks++;
      if (beat_cyc[3] - beat_cyc[0] !== 3) begin
        errors++;
        $display("FAIL mid_rate: got span %0d expected 3", beat_cyc[3] - beat_cyc[0]);
      end
    end
  endtask

  task automatic test_en_drop();
    bit ok;
    int es [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int occ [2];
    logic [7:0] ed;
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) push(k, 8'(k * 16 + i));
    @(posedge clk); #1 i_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (o_rden !== 4'd0) begin errors++; $display("FAIL en_rden: got %b expected 0000", o_rden); end
    end
    checks++;
    if (m_valid !== 1'b0 || beat_src.size() !== 1) begin
      errors++;
      $display("FAIL en_drain: got valid %b beats %0d expected valid 0 beats 1", m_valid, beat_src.size());
    end
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL en_busy: got %b expected 1", o_busy); end
    @(posedge clk); #1 i_en = 1'b1;
    wait_beats(8, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL en_timeout: got %0d beats expected 8", beat_src.size()); end
    else begin
      occ = '{0, 0};
      for (int i = 0; i < 8; i++) begin
        ed = 8'(es[i] * 16 + occ[es[i]]);
        occ[es[i]]++;
        checks++;
        if (beat_src[i] !== es[i] || beat_data[i] !== ed) begin
          errors++;
          $display("FAIL en_beat%0d: got src %0d data %h expected src %0d data %h",
                   i, beat_src[i], beat_data[i], es[i], ed);
        end
      end
      checks++;
      if (beat_cyc[7] - beat_cyc[1] !== 6) begin
        errors++;
        $display("FAIL en_rate: got span %0d expected 6", beat_cyc[7] - beat_cyc[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) push(k, 8'(k * 16 + i));
    wait_beats(5, 40, ok);
    rstn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (m_valid !== 1'b0 || o_rden !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_out: got valid %b rden %b expected 0 0000", m_valid, o_rden);
    end
    @(posedge clk); #1 rstn = 1'b1;
    clear_log();
    push(3, 8'h3A);
    push(0, 8'h0A);
    wait_beats(2, 20, ok);
    checks++;
    if (!ok || beat_src[0] !== 0 || beat_src[1] !== 3) begin
      errors++;
      $display("FAIL rstmid_cur: got %0d beats first src %0d expected 2 beats order 0,3",
               beat_src.size(), (beat_src.size() > 0) ? beat_src[0] : -1);
    end
  endtask

  task automatic test_random();
    int nb;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      m_ready = ($urandom_range(0, 3) != 0);
      i_en    = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < NSRC; k++)
        if ($urandom_range(0, 2) == 0) push(k, 8'($urandom));
    end
    i_en = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (!o_busy) break;
    end
    repeat (2) @(posedge clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rand_drain: busy %b expected 0", o_busy); end
    for (int k = 0; k < NSRC; k++) begin
      checks++;
      if (sb[k].size() !== 0) begin
        errors++;
        $display("FAIL rand_left: src %0d has %0d undelivered expected 0", k, sb[k].size());
      end
    end
    nb = beat_src.size();
    checks++;
    if (nb < 100) begin errors++; $display("FAIL rand_count: got %0d beats expected at least 100", nb); end
  endtask

  initial begin
    for (int k = 0; k < NSRC; k++) wp[k] = 4'd0;
    test_reset();
    test_single_src();
    test_all_src();
    test_backpressure();
    test_empty_mid_burst();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
